// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// Captures a byte, pulses tx_start, follows tx_busy to frame end, then enforces an inter-frame gap.
module uart_tx_arbiter #(
   parameter int unsigned START_W = 2,
   parameter logic [15:0] BUSY_TO = 16'd64,
   parameter logic [15:0] GAP     = 16'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic [15:0] tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic        tx_ok,
   output logic [1:0]  grant,
   output logic        err,
   output logic [1:0]  err_code,
   input  logic        err_clr
);

   typedef enum logic [2:0] {
      StIdle, StLaunch, StWaitBusy, StWaitDone, StGapWait, StError
   } state_e;

   localparam logic [15:0] LaunchLast = 16'(START_W - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [15:0] tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        rr_q, rr_d;
   logic        win1, can_accept, hs0, hs1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 16'd0;
         tx_data_q  <= 16'd0;
         tx_start_q <= 1'b0;
         grant_q    <= 2'b00;
         err_code_q <= 2'b00;
         rr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         grant_q    <= grant_d;
         err_code_q <= err_code_d;
         rr_q       <= rr_d;
      end
   end

   always_comb begin
      cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

      // rr_q == 0 favours ch0; with no valid request the favoured channel is the nominal winner
      if (req0_valid && req1_valid) win1 = rr_q;
      else if (req1_valid)          win1 = 1'b1;
      else if (req0_valid)          win1 = 1'b0;
      else                          win1 = rr_q;

      can_accept = (state_q == StIdle) && !tx_busy && tx_ok && !rst;
      req0_ready = can_accept && !win1;
      req1_ready = can_accept && win1;
      hs0        = req0_valid && req0_ready;
      hs1        = req1_valid && req1_ready;

      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = tx_start_q;
      grant_d    = grant_q;
      err_code_d = err_code_q;
      rr_d       = rr_q;

      case (state_q)
         StIdle: begin
            if (hs0 || hs1) begin
               tx_data_d  = {8'h00, hs1 ? req1_data : req0_data};
               grant_d    = hs1 ? 2'b10 : 2'b01;
               rr_d       = hs0;
               cnt_d      = 16'd0;
               tx_start_d = 1'b1;
               state_d    = StLaunch;
            end
         end
         StLaunch: begin
            if (cnt_q == LaunchLast) begin
               tx_start_d = 1'b0;
               cnt_d      = 16'd0;
               state_d    = StWaitBusy;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= BUSY_TO) begin
                  state_d    = StError;
                  err_code_d = 2'b01;
               end
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               grant_d = 2'b00;
               cnt_d   = 16'd0;
               state_d = (GAP == 16'd0) ? StIdle : StGapWait;
            end
         end
         StGapWait: begin
            cnt_d = cnt_inc;
            if (cnt_inc >= GAP) state_d = StIdle;
         end
         StError: begin
            if (err_clr) begin
               err_code_d = 2'b00;
               grant_d    = 2'b00;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Transmitter fault wins over any same-cycle timeout or frame completion
      if (!tx_ok && state_q != StIdle && state_q != StError) begin
         state_d    = StError;
         err_code_d = 2'b10;
         tx_start_d = 1'b0;
         grant_d    = grant_q;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign grant    = grant_q;
   assign err      = (state_q == StError);
   assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; a second instance with GAP=5 covers the inter-frame gap.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
   logic        tx_busy = 1'b0, tx_ok = 1'b1, err_clr = 1'b0;

   logic        req0_ready, req1_ready, tx_start, err;
   logic [15:0] tx_data;
   logic [1:0]  grant, err_code;
   logic        req0_ready_g, req1_ready_g, tx_start_g, err_g;
   logic [15:0] tx_data_g;
   logic [1:0]  grant_g, err_code_g;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_ok(tx_ok),
      .grant(grant), .err(err), .err_code(err_code), .err_clr(err_clr)
   );

   uart_tx_arbiter #(.GAP(16'd5)) dut_g (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready_g),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready_g),
      .tx_data(tx_data_g), .tx_start(tx_start_g), .tx_busy(tx_busy), .tx_ok(tx_ok),
      .grant(grant_g), .err(err_g), .err_code(err_code_g), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tx_busy = 1'b0; tx_ok = 1'b1; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // One arbitrated frame with a 4-cycle busy window; valids are left as the caller set them
   task automatic run_frame(input logic [1:0] exp_grant, input logic [15:0] exp_data);
      int i = 0;
      while (!(req0_ready || req1_ready) && i < 20) begin
         nxt();
         i++;
      end
      chk("rr_ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_grant});
      nxt();
      chk("rr_grant", {30'd0, grant}, {30'd0, exp_grant});
      chk("rr_data", {16'd0, tx_data}, {16'd0, exp_data});
      nxt();
      tx_busy = 1'b1;
      repeat (4) nxt();
      tx_busy = 1'b0;
      nxt();
      chk("rr_release", {30'd0, grant}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_tx_data", {16'd0, tx_data}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      rst = 1'b0;
      #1;

      // T1: single ch0 byte
      req0_valid = 1'b1; req0_data = 8'hA5;
      #1;
      chk("t1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
      nxt();
      chk("t1_tx_start1", {31'd0, tx_start}, 32'd1);
      chk("t1_grant", {30'd0, grant}, 32'd1);
      chk("t1_tx_data", {16'd0, tx_data}, 32'h00A5);
      chk("t1_ready_pulse", {31'd0, req0_ready}, 32'd0);
      req0_valid = 1'b0;
      nxt();
      chk("t1_tx_start2", {31'd0, tx_start}, 32'd1);
      nxt();
      chk("t1_tx_start_off", {31'd0, tx_start}, 32'd0);
      tx_busy = 1'b1;
      repeat (100) nxt();
      chk("t1_grant_hold", {30'd0, grant}, 32'd1);
      chk("t1_data_hold", {16'd0, tx_data}, 32'h00A5);
      tx_busy = 1'b0;
      nxt();
      chk("t1_grant_rel", {30'd0, grant}, 32'd0);
      req0_valid = 1'b1;
      #1;
      chk("t1_idle_ready", {31'd0, req0_ready}, 32'd1);
      req0_valid = 1'b0;

      // T2: round robin with both channels valid
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_data = 8'h22;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) run_frame(2'b01, 16'h0011);
         else            run_frame(2'b10, 16'h0022);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // T3: busy timeout on ch1
      do_reset();
      req1_valid = 1'b1; req1_data = 8'h33;
      #1;
      chk("t3_ready1", {30'd0, req1_ready, req0_ready}, 32'd2);
      nxt();
      chk("t3_grant", {30'd0, grant}, 32'd2);
      req1_valid = 1'b0;
      repeat (65) nxt();
      chk("t3_err_early", {31'd0, err}, 32'd0);
      nxt();
      chk("t3_err", {31'd0, err}, 32'd1);
      chk("t3_err_code", {30'd0, err_code}, 32'd1);
      chk("t3_grant_err", {30'd0, grant}, 32'd2);
      chk("t3_tx_start", {31'd0, tx_start}, 32'd0);
      req0_valid = 1'b1; req0_data = 8'h34;
      #1;
      chk("t3_readies_err", {30'd0, req1_ready, req0_ready}, 32'd0);
      err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      #1;
      chk("t3_err_clr", {29'd0, err, err_code}, 32'd0);
      chk("t3_grant_clr", {30'd0, grant}, 32'd0);
      chk("t3_ready_after", {31'd0, req0_ready}, 32'd1);
      nxt();
      chk("t3_next_grant", {30'd0, grant}, 32'd1);
      chk("t3_next_data", {16'd0, tx_data}, 32'h0034);
      req0_valid = 1'b0;

      // T4: tx_ok drop during WAIT_DONE
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h44;
      nxt();
      req0_valid = 1'b0;
      nxt();
      tx_busy = 1'b1;
      repeat (3) nxt();
      chk("t4_err_before", {31'd0, err}, 32'd0);
      tx_ok = 1'b0;
      nxt();
      chk("t4_err", {31'd0, err}, 32'd1);
      chk("t4_err_code", {30'd0, err_code}, 32'd2);
      chk("t4_tx_start", {31'd0, tx_start}, 32'd0);
      chk("t4_grant", {30'd0, grant}, 32'd1);
      tx_ok = 1'b1; tx_busy = 1'b0; err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      #1;
      chk("t4_recover", {28'd0, err, err_code, grant != 2'b00}, 32'd0);
      tx_ok = 1'b0; req0_valid = 1'b1;
      #1;
      chk("t4_idle_ok_block", {31'd0, req0_ready}, 32'd0);
      nxt();
      chk("t4_idle_ok_noerr", {31'd0, err}, 32'd0);
      tx_ok = 1'b1; req0_valid = 1'b0;

      // T5: GAP=5 instance, ch0 back-to-back
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h55;
      #1;
      chk("t5_ready_first", {31'd0, req0_ready_g}, 32'd1);
      nxt();
      nxt();
      tx_busy = 1'b1;
      repeat (3) nxt();
      tx_busy = 1'b0;
      repeat (5) nxt();
      chk("t5_gap_low", {31'd0, req0_ready_g}, 32'd0);
      nxt();
      chk("t5_gap_ready", {31'd0, req0_ready_g}, 32'd1);
      req0_valid = 1'b0;

      // T6: asynchronous reset during WAIT_DONE
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h66;
      nxt();
      req0_valid = 1'b0;
      nxt();
      tx_busy = 1'b1;
      repeat (3) nxt();
      chk("t6_grant_pre", {30'd0, grant}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_grant", {30'd0, grant}, 32'd0);
      chk("t6_async_data", {16'd0, tx_data}, 32'd0);
      chk("t6_async_misc", {28'd0, tx_start, err, err_code}, 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1; tx_busy = 1'b0;
      #1;
      chk("t6_ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_favour_ch0", {30'd0, req1_ready, req0_ready}, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
